// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports, the memory port and the
// busy flag of the data-memory arbiter.
//   m0_* : core LSU requester (req, we, addr, wdata, gnt, rvalid, rdata)
//   m1_* : program loader requester (same set plus m1_lock)
//   mem_*: single-port memory (we, addr, wd out of the arbiter; rd back in)
//   busy : one or more reads in flight
// Modports:
//   slave  : arbiter view
//   master : environment view (requesters and memory model)
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  mem_rd,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wd,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output mem_rd,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wd,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// Grants are combinational (round-robin on ties); the loader (m1) can take an
// exclusive lock that keeps the core LSU (m0) off the memory. Read responses
// are routed back through an RD_LAT-deep {valid, id} pipeline.
// Ports:
//   clk  : clock, all state on posedge
//   rstn : synchronous active-low reset; forces every output to 0 while low
//   bus  : dmem_arbiter_if.slave (requester handshakes, memory port, busy)
// Parameters: AW address width, DW data width, RD_LAT read latency (1..4).
module dmem_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input logic           clk,
    input logic           rstn,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {OPEN, LOCKED} lock_state_e;
    typedef enum logic {OWN_M0, OWN_M1} owner_e;

    lock_state_e       lock_q, lock_d;
    owner_e            last_q, last_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;

    logic          m1_rd_inflight;
    logic          unlock_ok;
    logic          m0_allowed;
    logic          gnt0, gnt1;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rsp_vld, rsp_id;

    // Any pending m1 read, including one returning this cycle, holds the lock.
    assign m1_rd_inflight = |(vld_q & id_q);
    assign unlock_ok      = !bus.m1_lock && !m1_rd_inflight;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_q <= OPEN;
            last_q <= OWN_M1;
            vld_q  <= '0;
            id_q   <= '0;
        end else begin
            lock_q <= lock_d;
            last_q <= last_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        last_d     = last_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        we         = 1'b0;
        addr       = '0;
        wd         = '0;
        vld_d      = '0;
        id_d       = '0;
        // The unlock condition is evaluated combinationally so m0 can be
        // granted in the very cycle the lock is released.
        m0_allowed = (lock_q == OPEN) || unlock_ok;

        if (rstn) begin
            if (bus.m0_req && m0_allowed && (!bus.m1_req || last_q == OWN_M1)) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0) begin
            we     = bus.m0_we;
            addr   = bus.m0_addr;
            wd     = bus.m0_wdata;
            last_d = OWN_M0;
        end else if (gnt1) begin
            we     = bus.m1_we;
            addr   = bus.m1_addr;
            wd     = bus.m1_wdata;
            last_d = OWN_M1;
        end

        case (lock_q)
            OPEN:    if (gnt1 && bus.m1_lock) lock_d = LOCKED;
            LOCKED:  if (unlock_ok)           lock_d = OPEN;
            default: lock_d = OPEN;
        endcase

        vld_d[0] = (gnt0 || gnt1) && !we;
        id_d[0]  = gnt1;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    assign rsp_vld = rstn && vld_q[RD_LAT-1];
    assign rsp_id  = id_q[RD_LAT-1];

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wd    = wd;
    assign bus.m0_rvalid = rsp_vld && !rsp_id;
    assign bus.m1_rvalid = rsp_vld && rsp_id;
    assign bus.m0_rdata  = (rsp_vld && !rsp_id) ? bus.mem_rd : '0;
    assign bus.m1_rdata  = (rsp_vld && rsp_id) ? bus.mem_rd : '0;
    assign bus.busy      = rstn && (|vld_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. Three instances with
// RD_LAT = 1, 2, 3 share clock and reset; each has its own memory model.
// Read responses are checked against a scoreboard of expected
// {instance, id, cycle, data}.
module tb_dmem_arbiter;

    localparam int NI = 3;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int unsigned cyc  = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_m0_req [NI], s_m0_we [NI], s_m1_req [NI], s_m1_we [NI], s_m1_lock [NI];
    logic [31:0] s_m0_addr [NI], s_m0_wdata [NI], s_m1_addr [NI], s_m1_wdata [NI];
    logic        o_m0_gnt [NI], o_m1_gnt [NI], o_m0_rv [NI], o_m1_rv [NI];
    logic        o_mem_we [NI], o_busy [NI];
    logic [31:0] o_m0_rdata [NI], o_m1_rdata [NI], o_mem_addr [NI], o_mem_wd [NI];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (32'h5A00_0000 | a);
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_dut
        dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

        assign bus.m0_req   = s_m0_req[k];
        assign bus.m0_we    = s_m0_we[k];
        assign bus.m0_addr  = s_m0_addr[k];
        assign bus.m0_wdata = s_m0_wdata[k];
        assign bus.m1_req   = s_m1_req[k];
        assign bus.m1_we    = s_m1_we[k];
        assign bus.m1_addr  = s_m1_addr[k];
        assign bus.m1_wdata = s_m1_wdata[k];
        assign bus.m1_lock  = s_m1_lock[k];

        assign o_m0_gnt[k]   = bus.m0_gnt;
        assign o_m1_gnt[k]   = bus.m1_gnt;
        assign o_m0_rv[k]    = bus.m0_rvalid;
        assign o_m1_rv[k]    = bus.m1_rvalid;
        assign o_m0_rdata[k] = bus.m0_rdata;
        assign o_m1_rdata[k] = bus.m1_rdata;
        assign o_mem_we[k]   = bus.mem_we;
        assign o_mem_addr[k] = bus.mem_addr;
        assign o_mem_wd[k]   = bus.mem_wd;
        assign o_busy[k]     = bus.busy;

        dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(k + 1)) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );

        // Memory model: read data appears k+1 cycles after the issue cycle.
        logic [31:0] mem  [0:255];
        logic        wr   [0:255];
        logic [31:0] pipe [0:k];
        logic [7:0]  ix;
        assign ix = bus.mem_addr[9:2];

        always @(posedge clk) begin
            if (!rstn) begin
                for (int i = 0; i < 256; i++) wr[i] <= 1'b0;
            end else if (bus.mem_we) begin
                mem[ix] <= bus.mem_wd;
                wr[ix]  <= 1'b1;
            end
            pipe[0] <= wr[ix] ? mem[ix] : init_val(bus.mem_addr);
            for (int i = 1; i <= k; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_rd = pipe[k];
    end

    typedef struct {
        int          inst;
        logic        id;
        int unsigned due;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int k, input logic id, input logic [31:0] d);
        exp_t e;
        e.inst = k;
        e.id   = id;
        e.due  = cyc + k + 1;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input int k, input logic id, input logic [31:0] d);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_rvalid observed inst=%0d id=%0d cyc=%0d data=%h expected none", k, id, cyc, d);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert ({k, id, cyc, d} === {e.inst, e.id, e.due, e.data}) else begin
                n_bad++;
                $error("FAIL rsp observed inst=%0d id=%0d cyc=%0d data=%h expected inst=%0d id=%0d cyc=%0d data=%h",
                       k, id, cyc, d, e.inst, e.id, e.due, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (o_m0_rv[k]) check_rsp(k, 1'b0, o_m0_rdata[k]);
            else chk($sformatf("m0_rdata_idle[%0d]", k), 128'(o_m0_rdata[k]), 128'd0);
            if (o_m1_rv[k]) check_rsp(k, 1'b1, o_m1_rdata[k]);
            else chk($sformatf("m1_rdata_idle[%0d]", k), 128'(o_m1_rdata[k]), 128'd0);
        end
    end

    task automatic drive(input int k,
                         input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1,
                         input logic lk);
        s_m0_req[k] = r0; s_m0_we[k] = w0; s_m0_addr[k] = a0; s_m0_wdata[k] = d0;
        s_m1_req[k] = r1; s_m1_we[k] = w1; s_m1_addr[k] = a1; s_m1_wdata[k] = d1;
        s_m1_lock[k] = lk;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) idle(k);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected memory-port values follow from whichever requester should win.
    task automatic expect_cyc(input string tag, input int k, input logic g0, g1, bsy);
        logic        we_e;
        logic [31:0] a_e, d_e;
        we_e = 1'b0;
        a_e  = '0;
        d_e  = '0;
        if (g0) begin
            we_e = s_m0_we[k]; a_e = s_m0_addr[k]; d_e = s_m0_wdata[k];
        end else if (g1) begin
            we_e = s_m1_we[k]; a_e = s_m1_addr[k]; d_e = s_m1_wdata[k];
        end
        chk($sformatf("%s[%0d]", tag, k),
            {60'd0, o_m0_gnt[k], o_m1_gnt[k], o_busy[k], o_mem_we[k], o_mem_addr[k], o_mem_wd[k]},
            {60'd0, g0, g1, bsy, we_e, a_e, d_e});
    endtask

    initial begin
        idle_all();
        rstn = 1'b0;
        repeat (2) tick();

        // Reset with every requester asserting
        for (int k = 0; k < NI; k++)
            drive(k, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h77, 1'b1);
        #1;
        for (int k = 0; k < NI; k++) expect_cyc("reset_outputs", k, 1'b0, 1'b0, 1'b0);
        tick();
        idle_all();
        rstn = 1'b1;

        // Round-robin tie on instance 0, m0 wins first after reset
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1111_0000 + i, 1'b0);
            #1;
            expect_cyc("rr_alternate", 0, (i % 2) == 0, (i % 2) == 1, (i % 2) == 1);
            if ((i % 2) == 0) push(0, 1'b0, init_val(32'h10));
            tick();
        end
        idle(0); #1; expect_cyc("rr_idle", 0, 1'b0, 1'b0, 1'b0); tick();

        // Single read, RD_LAT=1
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("rd_issue", 0, 1'b1, 1'b0, 1'b0); push(0, 1'b0, 32'hDEADBEEF); tick();
        idle(0); #1; expect_cyc("rd_busy", 0, 1'b0, 1'b0, 1'b1); tick();
        idle(0); #1; expect_cyc("rd_done", 0, 1'b0, 1'b0, 1'b0); tick();

        // Loader lock
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h55, 1'b1);
        #1; expect_cyc("lock_m1_wr", 0, 1'b0, 1'b1, 1'b0); tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1; expect_cyc("locked_m0_held", 0, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        #1; expect_cyc("locked_m1_rd", 0, 1'b0, 1'b1, 1'b0); push(0, 1'b1, init_val(32'h44)); tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("unlock_wait_rd", 0, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("unlock_m0_gnt", 0, 1'b1, 1'b0, 1'b0); push(0, 1'b0, init_val(32'h40)); tick();
        idle(0); #1; expect_cyc("post_unlock", 0, 1'b0, 1'b0, 1'b1); tick();

        // Back-to-back reads, RD_LAT=3
        drive(2, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("pipe_rd0", 2, 1'b1, 1'b0, 1'b0); push(2, 1'b0, init_val(32'h80)); tick();
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, 1'b0);
        #1; expect_cyc("pipe_rd1", 2, 1'b0, 1'b1, 1'b1); push(2, 1'b1, init_val(32'h84)); tick();
        drive(2, 1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("pipe_rd2", 2, 1'b1, 1'b0, 1'b1); push(2, 1'b0, init_val(32'h88)); tick();
        for (int i = 0; i < 4; i++) begin
            idle(2); #1; expect_cyc("pipe_drain", 2, 1'b0, 1'b0, i < 3); tick();
        end

        // Reset with a read in flight (RD_LAT=2) and instance 0 locked
        drive(1, 1'b1, 1'b0, 32'h90, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h204, 32'h66, 1'b1);
        #1;
        expect_cyc("rst_pre_rd", 1, 1'b1, 1'b0, 1'b0);
        expect_cyc("rst_pre_lock", 0, 1'b0, 1'b1, 1'b0);
        tick();
        rstn = 1'b0;
        for (int k = 0; k < NI; k++)
            drive(k, 1'b1, 1'b0, 32'h94, 32'h0, 1'b1, 1'b0, 32'h98, 32'h0, 1'b1);
        #1;
        for (int k = 0; k < NI; k++) expect_cyc("rst_mid", k, 1'b0, 1'b0, 1'b0);
        tick();
        rstn = 1'b1;
        idle_all();
        drive(0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        expect_cyc("rst_lock_open", 0, 1'b1, 1'b0, 1'b0); push(0, 1'b0, init_val(32'h48));
        expect_cyc("rst_discard", 1, 1'b0, 1'b0, 1'b0);
        tick();
        idle(0);
        drive(1, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b1, 1'b0, 32'hA4, 32'h0, 1'b0);
        #1; expect_cyc("rst_ptr_m0", 1, 1'b1, 1'b0, 1'b0); push(1, 1'b0, init_val(32'hA0)); tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA4, 32'h0, 1'b0);
        #1; expect_cyc("rst_ptr_m1", 1, 1'b0, 1'b1, 1'b1); push(1, 1'b1, init_val(32'hA4)); tick();
        idle(1); #1; expect_cyc("rst_busy", 1, 1'b0, 1'b0, 1'b1); tick();
        repeat (3) tick();

        // Write then read the same address
        drive(0, 1'b1, 1'b1, 32'h300, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("wr_issue", 0, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; expect_cyc("rd_after_wr", 0, 1'b1, 1'b0, 1'b0); push(0, 1'b0, 32'h12345678); tick();
        idle(0); #1; expect_cyc("rd_after_wr_busy", 0, 1'b0, 1'b0, 1'b1); tick();

        repeat (5) tick();
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter RD_LAT, default 1, legal 1..4: cycles from the issue cycle to valid mem_rd.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 m0_req / m1_req  in  1  access request from the core LSU (m0) or the program loader (m1), held until granted.
REQ-007 m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-008 m0_addr / m1_addr  in  AW  byte address, passed through unmodified.
REQ-009 m0_wdata / m1_wdata  in  DW  write data.
REQ-010 m1_lock  in  1  loader exclusive-access request.
REQ-011 m0_gnt / m1_gnt  out  1  request accepted and issued to memory this cycle.
REQ-012 m0_rvalid / m1_rvalid  out  1  read data valid for that requester this cycle.
REQ-013 m0_rdata / m1_rdata  out  DW  read data; equals mem_rd when the matching rvalid is 1, else 0.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  AW  memory address.
REQ-016 mem_wd  out  DW  memory write data.
REQ-017 mem_rd  in  DW  memory read data, valid RD_LAT cycles after issue.
REQ-018 busy  out  1  one or more reads in flight.

Function
REQ-019 Grant is combinational: in any cycle with rstn=1, at most one gnt is 1, and mem_we/mem_addr/mem_wd carry the granted requester's we/addr/wdata in that same cycle.
REQ-020 With no grant: mem_we=0, mem_addr=0, mem_wd=0.
REQ-021 With exactly one requester: that requester is granted, unless a lock blocks it (REQ-023).
REQ-022 With both requesting and no lock: round-robin; grant the requester not granted most recently; the last-granted pointer updates only on a grant.
REQ-023 Lock state machine, states OPEN and LOCKED:
- OPEN -> LOCKED on a cycle where m1_gnt=1 and m1_lock=1.
- In LOCKED, m0 is never granted.
- LOCKED -> OPEN on the first cycle where m1_lock=0 and no m1 read is in flight; m0 may be granted in that same cycle.
REQ-024 Read tracking: an RD_LAT-deep shift register of {valid, id}, shifting every cycle. A read grant enters {1, requester}; a write grant or no grant enters {0, x}.
REQ-025 When the shift-register output entry is valid, rvalid is 1 for exactly one cycle for that id, with rdata=mem_rd.
REQ-026 Back-to-back reads are issued every cycle with no bubble; responses return in issue order.
REQ-027 Writes produce no rvalid. A read issued the cycle after a write to the same address returns the new data (memory guarantee, passed through).
REQ-028 busy=1 iff any shift-register entry is valid.
REQ-029 A requester may drop req while ungranted; no grant and no state change result.

Reset
REQ-030 While rstn=0: all gnt=0, rvalid=0, rdata=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0, regardless of req.
REQ-031 Reset clears every shift-register entry, sets the lock state to OPEN, and sets the last-granted pointer to m1 (so m0 wins the first tie).
REQ-032 Reads in flight when reset asserts are discarded; no rvalid appears for them after reset releases.

Verification
REQ-033 RD_LAT=1; m0 reads addr 0x100 (mem holds 0xDEADBEEF) -> m0_gnt=1 at cycle N; m0_rvalid=1 with m0_rdata=0xDEADBEEF at N+1; busy=1 during N+1 only.
REQ-034 Both request every cycle for 4 cycles after reset -> grants alternate m0, m1, m0, m1.
REQ-035 m1 writes 0x55 to 0x200 with m1_lock=1, then m1_lock=0 while m0 requests continuously -> m0 is held off while locked; m0_gnt=1 on the first cycle with m1_lock=0 and no m1 read in flight.
REQ-036 RD_LAT=3; reads issued at cycles N (m0), N+1 (m1), N+2 (m0) -> rvalid at N+3 (m0), N+4 (m1), N+5 (m0), each with its own data.
REQ-037 rstn=0 one cycle after an m0 read issue with RD_LAT=2 -> no m0_rvalid at any later cycle; all outputs 0 during reset.
REQ-038 Write 0x12345678 to 0x300 at cycle N, read 0x300 at N+1 -> rvalid carries 0x12345678; no rvalid generated for the write.
